// File: rtl/gray_updown_counter_if.sv
// gray_updown_counter_if: control and status bundle for gray_updown_counter.
interface gray_updown_counter_if #(parameter int WIDTH = 8);
    logic             en;
    logic             up;
    logic             load;
    logic             load_is_gray;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             ovf;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, up, load, load_is_gray, load_val,
        input  bin_out, gray_out, ovf, at_max, at_min
    );

    modport slave (
        input  en, up, load, load_is_gray, load_val,
        output bin_out, gray_out, ovf, at_max, at_min
    );
endinterface

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down counter holding binary and Gray count registers,
// loadable from binary or Gray, with wrap or saturate behaviour at the range ends.
module gray_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input logic                   clk,
    input logic                   rst,
    gray_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d, load_bin, step;
    logic             ovf_q, ovf_d, at_max_q, at_max_d, at_min_q, at_min_d, at_end;

    always_comb begin
        load_bin = '0;
        // Each binary bit is the parity of the Gray bits at and above it.
        for (int i = 0; i < WIDTH; i++) load_bin[i] = ^(bus.load_val >> i);
        at_end   = bus.up ? (&bin_q) : (~|bin_q);
        step     = bus.up ? bin_q + 1'b1 : bin_q - 1'b1;
        bin_d    = bus.load ? (bus.load_is_gray ? load_bin : bus.load_val) :
                   !bus.en ? bin_q :
                   (SATURATE != 0 && at_end) ? bin_q : step;
        ovf_d    = !bus.load && bus.en && at_end;
        gray_d   = bin_d ^ (bin_d >> 1);
        at_max_d = &bin_d;
        at_min_d = ~|bin_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= RV;
            gray_q   <= RV ^ (RV >> 1);
            ovf_q    <= 1'b0;
            at_max_q <= &RV;
            at_min_q <= ~|RV;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            ovf_q    <= ovf_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.ovf      = ovf_q;
    assign bus.at_max   = at_max_q;
    assign bus.at_min   = at_min_q;
endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
Parametrised up/down counter that keeps a binary count and its reflected Gray-code equivalent in registers, updated on the same clock edge. It can be loaded from either a binary or a Gray-coded value, using an internal Gray-to-binary conversion. It is the sequential successor to the team's fixed 8-bit combinational Gray/binary converters. Intended uses are clock-domain-crossing pointers and position encoders.

Parameters:
WIDTH, 8, counter width in bits (minimum 2).
RESET_VAL, 0, binary count value applied on reset (must be < 2**WIDTH).
SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at 0 / all-ones.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable for this cycle.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous load strobe.
load_is_gray  input  1  1 = load_val is Gray-coded; 0 = load_val is binary.
load_val  input  WIDTH  value to load.
bin_out  output  WIDTH  registered binary count.
gray_out  output  WIDTH  registered Gray code of bin_out, i.e. bin_out ^ (bin_out >> 1).
ovf  output  1  one-cycle pulse on a wrap (SATURATE=0) or on a blocked step (SATURATE=1).
at_max  output  1  registered; 1 when bin_out is all-ones.
at_min  output  1  registered; 1 when bin_out is zero.

Behaviour:
- Reset (async, rst=1): bin_out=RESET_VAL, gray_out=RESET_VAL^(RESET_VAL>>1), ovf=0. at_max and at_min reflect RESET_VAL. Reset asserted mid-count overrides everything immediately, with no waiting for a clock edge.
- Priority per rising edge: load > en > hold.
- Load: the next binary value is load_val if load_is_gray=0.
  - If load_is_gray=1, the next binary value is the Gray-to-binary conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] down to bit 0.
  - ovf=0 on a load cycle. en is ignored on a load cycle.
- Count (en=1, load=0):
  - up=1: next = bin_out+1.
  - up=0: next = bin_out-1.
  - Arithmetic is modulo 2**WIDTH.
- Wrap mode (SATURATE=0):
  - Counting up from all-ones goes to 0, with ovf=1 for the next cycle.
  - Counting down from 0 goes to all-ones, with ovf=1.
- Saturate mode (SATURATE=1):
  - Counting up at all-ones, or down at 0, holds the count with ovf=1.
  - gray_out is unchanged on a blocked step.
- Hold (en=0, load=0): all count registers keep their value; ovf=0.
- Latency: every output reflects the cycle-N inputs after edge N+1. There is no combinational path from inputs to outputs.
- gray_out is registered from the next binary value, never computed combinationally from bin_out at the output. It is always consistent with bin_out.
- Invariant: on any count step that is not a load, gray_out differs from its previous value in exactly one bit. This includes the wrap step. A blocked saturate step changes no bits.
- Direction may change on any cycle with no dead cycle.
- ovf is deasserted on every cycle without a wrap or blocked event.

Test Plan (WIDTH=4 unless stated):
- Reset with RESET_VAL=5: assert rst mid-count -> immediately bin_out=0101, gray_out=0111, ovf=0, at_max=0, at_min=0.
- Up count of 16 steps from 0, SATURATE=0 -> gray_out follows 0000,0001,0011,0010,0110,…,1000 then 0000. Exactly one bit toggles per step; ovf=1 only on the 1111->0000 step.
- Down count from 0, SATURATE=0 -> bin_out=1111, gray_out=1000, ovf=1 for one cycle. Up count at 1111 with SATURATE=1 -> holds 1111, ovf=1 each blocked cycle.
- Gray load with load_val=1101, load_is_gray=1 -> bin_out=1001, gray_out=1101. Binary load with load_val=1101 -> bin_out=1101, gray_out=1011.
- Simultaneous load=1 and en=1 with load_val=0011 binary -> count=0011 and no increment applied. Next cycle with en=1 and up=0 -> 0010.
- WIDTH=8 random run of 1000 cycles with random en/up/load -> a scoreboard model matches bin_out, gray_out == bin_out^(bin_out>>1) every cycle, and the one-bit-change property holds on every non-load step.
